// File: rtl/loader_pkg.sv
// Shared constants and FSM state encoding for the instruction memory loader.
package loader_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_ram.sv
// Single-port instruction storage with synchronous read; contents are never reset.
module instr_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data only moves on a read, so the last fetched word is held otherwise.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Program download / fetch front end for an instruction RAM.
// Optional running-XOR checksum output enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AUTO_INC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              download_program,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              addr_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W:0]   word_count_q;
  logic              addr_err_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              fetch_valid_q;
  logic              fetch_zero_q;

  logic              load_active;
  logic              enter_load;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic              beat;
  logic              accept;
  logic              fetch_go;
  logic              fetch_in_range;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign load_active    = (state_q == LOAD);
  assign enter_load     = ((state_q == IDLE) || (state_q == RUN)) && download_program;
  assign wr_addr        = (AUTO_INC != 0) ? wr_ptr_q : load_addr;
  assign wr_in_range    = ({1'b0, wr_addr} < DEPTH_W);
  assign beat           = load_active && load_valid;
  assign accept         = beat && wr_in_range;
  // A fetch in the cycle that enters LOAD is dropped so LOAD never shows valid data.
  assign fetch_go       = !load_active && !enter_load && fetch_en;
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
  assign ram_en         = accept || (fetch_go && fetch_in_range);
  assign ram_addr       = load_active ? wr_addr : fetch_addr;

  instr_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (accept),
    .addr_i  (ram_addr),
    .wdata_i (load_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      word_count_q  <= '0;
      addr_err_q    <= 1'b0;
      wr_ptr_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_zero_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (download_program) begin
            state_q      <= LOAD;
            word_count_q <= '0;
            addr_err_q   <= 1'b0;
            wr_ptr_q     <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_count_q != DEPTH_W) begin
              word_count_q <= word_count_q + 1'b1;
            end
            wr_ptr_q <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
          end
          if (beat && !wr_in_range) begin
            addr_err_q <= 1'b1;
          end
          if (!download_program) begin
            state_q <= DONE;
          end
        end
        default: state_q <= RUN;
      endcase

      if (load_active || enter_load) begin
        fetch_valid_q <= 1'b0;
        fetch_zero_q  <= 1'b1;
      end else if (fetch_en) begin
        fetch_valid_q <= 1'b1;
        fetch_zero_q  <= !fetch_in_range;
      end else begin
        fetch_valid_q <= 1'b0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (enter_load) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q ^ load_data;
    end
  end

  assign checksum = checksum_q;
`endif

  assign load_ready  = load_active;
  assign load_done   = (state_q == DONE);
  assign word_count  = word_count_q;
  assign addr_err    = addr_err_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: default, AUTO_INC/DEPTH=4 and DEPTH=200 instances.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (DATA_W=16, DEPTH=256)
  logic        a_dp = 0, a_lv = 0, a_fe = 0;
  logic [7:0]  a_la = 0, a_fa = 0;
  logic [15:0] a_ld = 0;
  logic        a_ready, a_fv, a_done, a_err;
  logic [15:0] a_fd;
  logic [8:0]  a_wc;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] a_cs, b_cs, c_cs;
`endif

  // Instance B: AUTO_INC=1, DEPTH=4
  logic        b_dp = 0, b_lv = 0, b_fe = 0;
  logic [1:0]  b_la = 0, b_fa = 0;
  logic [15:0] b_ld = 0;
  logic        b_ready, b_fv, b_done, b_err;
  logic [15:0] b_fd;
  logic [2:0]  b_wc;

  // Instance C: DEPTH=200
  logic        c_dp = 0, c_lv = 0, c_fe = 0;
  logic [7:0]  c_la = 0, c_fa = 0;
  logic [15:0] c_ld = 0;
  logic        c_ready, c_fv, c_done, c_err;
  logic [15:0] c_fd;
  logic [8:0]  c_wc;

  instr_mem_loader u_a (
    .clk(clk), .rst_n(rst_n), .download_program(a_dp), .load_valid(a_lv),
    .load_ready(a_ready), .load_addr(a_la), .load_data(a_ld), .fetch_en(a_fe),
    .fetch_addr(a_fa), .fetch_data(a_fd), .fetch_valid(a_fv), .load_done(a_done),
    .word_count(a_wc), .addr_err(a_err)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(a_cs)
`endif
  );

  instr_mem_loader #(.DEPTH(4), .AUTO_INC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .download_program(b_dp), .load_valid(b_lv),
    .load_ready(b_ready), .load_addr(b_la), .load_data(b_ld), .fetch_en(b_fe),
    .fetch_addr(b_fa), .fetch_data(b_fd), .fetch_valid(b_fv), .load_done(b_done),
    .word_count(b_wc), .addr_err(b_err)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(b_cs)
`endif
  );

  instr_mem_loader #(.DEPTH(200)) u_c (
    .clk(clk), .rst_n(rst_n), .download_program(c_dp), .load_valid(c_lv),
    .load_ready(c_ready), .load_addr(c_la), .load_data(c_ld), .fetch_en(c_fe),
    .fetch_addr(c_fa), .fetch_data(c_fd), .fetch_valid(c_fv), .load_done(c_done),
    .word_count(c_wc), .addr_err(c_err)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(c_cs)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    check("rst_ready", a_ready, 0);
    check("rst_fv", a_fv, 0);
    check("rst_fd", a_fd, 0);
    check("rst_done", a_done, 0);
    check("rst_wc", a_wc, 0);
    check("rst_err", a_err, 0);

    // Basic download of two words, then fetch them back
    a_dp = 1; tick();
    check("load_ready", a_ready, 1);
    a_lv = 1; a_la = 8'd10; a_ld = 16'h2005; tick();
    a_la = 8'd11; a_ld = 16'h1FC2; a_dp = 0; tick();
    check("done_pulse", a_done, 1);
    check("wc_two", a_wc, 2);
    check("ready_done", a_ready, 0);
    a_lv = 0; tick();
    check("done_end", a_done, 0);
    a_fe = 1; a_fa = 8'd10; tick();
    check("fetch10_v", a_fv, 1);
    check("fetch10_d", a_fd, 16'h2005);
    a_fa = 8'd11; tick();
    check("fetch11_v", a_fv, 1);
    check("fetch11_d", a_fd, 16'h1FC2);
    a_fe = 0; tick();
    check("idle_fv", a_fv, 0);
    check("hold_fd", a_fd, 16'h1FC2);

    // Fetch requests during LOAD are ignored
    a_dp = 1; a_fe = 1; a_fa = 8'd10; tick();
    tick();
    check("loadfetch_v", a_fv, 0);
    check("loadfetch_d", a_fd, 0);
    a_fe = 0;

    // Reset after three beats aborts the download but keeps the words
    a_lv = 1; a_la = 8'd20; a_ld = 16'h1111; tick();
    a_la = 8'd21; a_ld = 16'h2222; tick();
    a_la = 8'd22; a_ld = 16'h3333; tick();
    check("wc_three", a_wc, 3);
    a_lv = 0; a_dp = 0; rst_n = 0; tick();
    rst_n = 1;
    check("mid_ready", a_ready, 0);
    check("mid_fv", a_fv, 0);
    check("mid_fd", a_fd, 0);
    check("mid_done", a_done, 0);
    check("mid_wc", a_wc, 0);
    check("mid_err", a_err, 0);
    a_fe = 1; a_fa = 8'd20; tick();
    check("keep20", a_fd, 16'h1111);
    a_fa = 8'd21; tick();
    check("keep21", a_fd, 16'h2222);
    a_fa = 8'd22; tick();
    check("keep22", a_fd, 16'h3333);
    a_fa = 8'd10; tick();
    check("keep10", a_fd, 16'h2005);
    a_fe = 0;

    // Checksum download
    a_dp = 1; tick();
    a_lv = 1; a_la = 8'd30; a_ld = 16'h00FF; tick();
    a_la = 8'd31; a_ld = 16'h0F0F; a_dp = 0; tick();
    check("cs_done", a_done, 1);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", a_cs, 16'h0FF0);
`endif
    a_lv = 0; tick();

    // AUTO_INC with DEPTH=4: five beats wrap the pointer, count saturates
    b_dp = 1; tick();
    b_lv = 1; b_la = 2'd3;
    b_ld = 16'h000A; tick();
    b_ld = 16'h000B; tick();
    b_ld = 16'h000C; tick();
    b_ld = 16'h000D; tick();
    b_ld = 16'h000E; b_dp = 0; tick();
    check("ai_done", b_done, 1);
    check("ai_wc_sat", b_wc, 4);
    b_lv = 0; tick();
    b_fe = 1; b_fa = 2'd0; tick();
    check("ai_mem0", b_fd, 16'h000E);
    b_fa = 2'd1; tick();
    check("ai_mem1", b_fd, 16'h000B);
    b_fa = 2'd2; tick();
    check("ai_mem2", b_fd, 16'h000C);
    b_fa = 2'd3; tick();
    check("ai_mem3", b_fd, 16'h000D);
    b_fe = 0;

    // DEPTH=200: out-of-range beat and fetch
    c_dp = 1; tick();
    c_lv = 1; c_la = 8'd5; c_ld = 16'h5555; tick();
    check("oor_wc1", c_wc, 1);
    check("oor_err0", c_err, 0);
    c_la = 8'd250; c_ld = 16'hDEAD; tick();
    check("oor_err1", c_err, 1);
    check("oor_wc_kept", c_wc, 1);
    c_lv = 0; c_dp = 0; tick();
    check("oor_sticky", c_err, 1);
    tick();
    c_fe = 1; c_fa = 8'd250; tick();
    check("oor_fetch_v", c_fv, 1);
    check("oor_fetch_d", c_fd, 0);
    c_fa = 8'd5; tick();
    check("c_fetch5", c_fd, 16'h5555);
    c_fe = 0; c_dp = 1; tick();
    check("err_cleared", c_err, 0);
    check("wc_cleared", c_wc, 0);
    c_dp = 0; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
